// File: rtl/hazard_unit_pkg.sv
// Shared types for the hazard unit: resolution state, shadow pipeline entry,
// and the forward-select width helper.
package hazard_unit_pkg;

  localparam int DEF_ADDR_WIDTH = 5;
  // Shadow entries carry addresses at a fixed maximum width so the struct
  // stays independent of each instance's ADDR_WIDTH.
  localparam int ADDR_MAX = 16;

  typedef logic [ADDR_MAX-1:0] addr_t;

  typedef enum logic [1:0] {
    RUN,
    LOAD_USE,
    MEM_WAIT,
    FLUSH
  } hazard_state_e;

  typedef struct packed {
    logic  valid;
    addr_t rd_addr;
    logic  we;
    logic  is_load;
  } shadow_entry_t;

  function automatic int fwd_sel_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// ID-stage request / pipeline control bundle between the pipeline (master)
// and the hazard unit (slave). HAZARD_PERF_CNT_EN adds the perf counters.
interface hazard_unit_if #(
  parameter int ADDR_WIDTH = hazard_unit_pkg::DEF_ADDR_WIDTH,
  parameter int NUM_RD     = 2,
  parameter int DEPTH      = 2
);
  localparam int SW = hazard_unit_pkg::fwd_sel_width(DEPTH);

  logic                         id_valid_i;
  logic [NUM_RD-1:0]            id_use_rs_i;
  logic [NUM_RD*ADDR_WIDTH-1:0] id_rs_addr_i;
  logic [ADDR_WIDTH-1:0]        id_rd_addr_i;
  logic                         id_rd_we_i;
  logic                         id_is_load_i;
  logic                         branch_taken_i;
  logic                         lsu_busy_i;
  logic                         fetch_stall_o;
  logic [DEPTH:0]               stall_o;
  logic [DEPTH:0]               clear_o;
  logic [NUM_RD*SW-1:0]         fwd_sel_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]                  stall_cnt_o;
  logic [31:0]                  flush_cnt_o;
`endif

  modport master (
`ifdef HAZARD_PERF_CNT_EN
    input  stall_cnt_o, flush_cnt_o,
`endif
    output id_valid_i, id_use_rs_i, id_rs_addr_i, id_rd_addr_i, id_rd_we_i,
    output id_is_load_i, branch_taken_i, lsu_busy_i,
    input  fetch_stall_o, stall_o, clear_o, fwd_sel_o
  );

  modport slave (
`ifdef HAZARD_PERF_CNT_EN
    output stall_cnt_o, flush_cnt_o,
`endif
    input  id_valid_i, id_use_rs_i, id_rs_addr_i, id_rd_addr_i, id_rd_we_i,
    input  id_is_load_i, branch_taken_i, lsu_busy_i,
    output fetch_stall_o, stall_o, clear_o, fwd_sel_o
  );

endinterface

// File: rtl/hazard_unit_fwd_match.sv
// One read port against all shadow stages: youngest matching stage wins;
// a load that is not yet forwardable raises load_hit instead of being selected.
module hazard_fwd_match
  import hazard_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = 2,
  parameter int LOAD_READY = 2
) (
  input  logic                                use_rs,
  input  logic [ADDR_WIDTH-1:0]               rs_addr,
  input  shadow_entry_t [DEPTH:1]             entries,
  output logic [fwd_sel_width(DEPTH)-1:0]     sel,
  output logic                                load_hit
);
  localparam int SW = fwd_sel_width(DEPTH);

  always_comb begin
    logic found;
    logic hit;
    logic early_load;
    sel        = '0;
    load_hit   = 1'b0;
    found      = 1'b0;
    hit        = 1'b0;
    early_load = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      hit = use_rs && (rs_addr != '0) && entries[k].valid && entries[k].we &&
            (entries[k].rd_addr == addr_t'(rs_addr));
      early_load = entries[k].is_load && (k < LOAD_READY);
      if (hit && !found) begin
        found = 1'b1;
        if (!early_load) sel = SW'(k);
      end
      if (hit && early_load) load_hit = 1'b1;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: forwarding selects, load-use bubbles, memory freeze
// and branch flush. Macro HAZARD_PERF_CNT_EN adds stall/flush counters.
//
// state    | meaning
// RUN      | no hazard, every stage advances
// LOAD_USE | ID needs a load result not yet forwardable: hold IF/ID, bubble EX
// MEM_WAIT | memory access outstanding: whole pipeline frozen
// FLUSH    | taken branch (live or pending): bubble IF/ID and EX, fetch continues
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_RD     = 2,
  parameter int DEPTH      = 2,
  parameter int LOAD_READY = 2
) (
  input logic          clk,
  input logic          rst,
  hazard_unit_if.slave bus
);
  localparam int SW = fwd_sel_width(DEPTH);

  shadow_entry_t [DEPTH:1]   shadow;
  shadow_entry_t [DEPTH-1:0] src;
  logic [NUM_RD-1:0]         load_hit;
  logic [NUM_RD*SW-1:0]      fwd_sel;
  logic [DEPTH:0]            stall;
  logic [DEPTH:0]            clear;
  logic                      fetch_stall;
  logic                      pending;
  logic                      hazard;
  hazard_state_e             state;

  // src[k] is what stage k+1 captures when it advances; src[0] is ID.
  always_comb begin
    src            = '0;
    src[0].valid   = bus.id_valid_i;
    src[0].rd_addr = addr_t'(bus.id_rd_addr_i);
    src[0].we      = bus.id_rd_we_i;
    src[0].is_load = bus.id_is_load_i;
    for (int k = 1; k < DEPTH; k++) src[k] = shadow[k];
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    hazard_fwd_match #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH),
      .LOAD_READY (LOAD_READY)
    ) u_match (
      .use_rs   (bus.id_use_rs_i[p]),
      .rs_addr  (bus.id_rs_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH]),
      .entries  (shadow),
      .sel      (fwd_sel[p*SW +: SW]),
      .load_hit (load_hit[p])
    );
  end

  assign hazard = bus.id_valid_i && (|load_hit);

  always_comb begin
    state = RUN;
    if (bus.lsu_busy_i)                          state = MEM_WAIT;
    else if (bus.branch_taken_i || pending)      state = FLUSH;
    else if (hazard)                             state = LOAD_USE;
  end

  always_comb begin
    stall       = '0;
    clear       = '0;
    fetch_stall = 1'b0;
    if (rst) begin
      clear = '1;
    end else begin
      case (state)
        LOAD_USE: begin
          fetch_stall = 1'b1;
          stall[0]    = 1'b1;
          clear[1]    = 1'b1;
        end
        MEM_WAIT: begin
          fetch_stall = 1'b1;
          stall       = '1;
        end
        FLUSH:    clear[1:0] = 2'b11;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow  <= '0;
      pending <= 1'b0;
    end else begin
      for (int k = 1; k <= DEPTH; k++) begin
        if (clear[k])       shadow[k] <= '0;
        else if (!stall[k]) shadow[k] <= src[k-1];
      end
      // A branch seen during a memory freeze is replayed as soon as it ends.
      if (state == FLUSH)                             pending <= 1'b0;
      else if (bus.lsu_busy_i && bus.branch_taken_i)  pending <= 1'b1;
    end
  end

  assign bus.fetch_stall_o = fetch_stall;
  assign bus.stall_o       = stall;
  assign bus.clear_o       = clear;
  assign bus.fwd_sel_o     = fwd_sel;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((state == LOAD_USE || state == MEM_WAIT) && stall_cnt != '1)
        stall_cnt <= stall_cnt + 32'd1;
      if (state == FLUSH && flush_cnt != '1)
        flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign bus.stall_cnt_o = stall_cnt;
  assign bus.flush_cnt_o = flush_cnt;
`endif

endmodule
